// File: rtl/ctrl_queue_pkg.sv
// Shared types for the pipelined-CPU control delay line.
// ctrl_bundle_t is the decoded control word that rides alongside each
// instruction; CTRL_BUBBLE is its "do nothing" encoding.
package ctrl_queue_pkg;

    typedef struct packed {
        logic       ReadMem;
        logic [1:0] RegWData;
        logic       MemWr;
        logic       FwdMem;
    } ctrl_bundle_t;

    localparam int CTRL_W = $bits(ctrl_bundle_t);

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_pipe_queue_if.sv
// Producer/consumer bus of the control delay line: the entry handshake,
// the output stage and the per-stage taps used by hazard/forwarding logic.
interface ctrl_pipe_queue_if
    import ctrl_queue_pkg::*;
#(
    parameter int WIDTH = CTRL_W,
    parameter int DEPTH = 2
) ();

    logic [WIDTH-1:0]       in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       out_data;
    logic                   out_valid;
    logic [DEPTH*WIDTH-1:0] tap_data;
    logic [DEPTH-1:0]       tap_valid;

    // Decode/issue side: supplies control words, observes the queue.
    modport master (
        output in_data, in_valid,
        input  in_ready, out_data, out_valid, tap_data, tap_valid
    );

    // The queue itself.
    modport slave (
        input  in_data, in_valid,
        output in_ready, out_data, out_valid, tap_data, tap_valid
    );

endinterface

// File: rtl/ctrl_queue_stage.sv
// One valid+data register of the control delay line.
// Priority: kill (bubble) > hold (keep) > load (take d_*) > bubble.
// The final "bubble" case is what the top uses to insert a bubble behind
// an upstream stall.
module ctrl_queue_stage #(
    parameter int               WIDTH  = 5,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             hold,
    input  logic             kill,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_data,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_data
);

    logic             nxt_valid;
    logic [WIDTH-1:0] nxt_data;

    // Select next contents of this stage in priority order.
    always_comb begin
        nxt_valid = 1'b0;
        nxt_data  = BUBBLE;
        if (kill) begin
            nxt_valid = 1'b0;
            nxt_data  = BUBBLE;
        end else if (hold) begin
            nxt_valid = q_valid;
            nxt_data  = q_data;
        end else if (load) begin
            nxt_valid = d_valid;
            nxt_data  = d_data;
        end
    end

    // Stage register; reset empties the stage to a bubble at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_valid <= 1'b0;
            q_data  <= BUBBLE;
        end else begin
            q_valid <= nxt_valid;
            q_data  <= nxt_data;
        end
    end

endmodule

// File: rtl/ctrl_pipe_queue.sv
// ctrl_pipe_queue: parametrised control-signal delay line.
// Carries a WIDTH-bit control bundle plus valid through DEPTH stages with
// per-stage stall (propagating upstream), per-stage flush and stage taps.
// Optional feature macro CTRL_PIPE_QUEUE_OCC_EN adds the occ (valid-stage
// count) and bubble_cnt (saturating bubble-insertion count) outputs.
module ctrl_pipe_queue
    import ctrl_queue_pkg::*;
#(
    parameter int               WIDTH  = CTRL_W,
    parameter int               DEPTH  = 2,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DEPTH-1:0]             stall,
    input  logic [DEPTH-1:0]             flush,
`ifdef CTRL_PIPE_QUEUE_OCC_EN
    output logic [$clog2(DEPTH+1)-1:0]   occ,
    output logic [15:0]                  bubble_cnt,
`endif
    ctrl_pipe_queue_if.slave             q
);

    logic [DEPTH-1:0] h;
    logic [DEPTH-1:0] ld;
    logic [DEPTH-1:0] src_v;
    logic [WIDTH-1:0] src_d [DEPTH];
    logic [DEPTH-1:0] sv;
    logic [WIDTH-1:0] sd    [DEPTH];

    // Hold chain: a stall anywhere downstream freezes this stage too.
    always_comb begin
        h = '0;
        h[DEPTH-1] = stall[DEPTH-1];
        for (int i = DEPTH - 2; i >= 0; i--) begin
            h[i] = stall[i] | h[i+1];
        end
    end

    // Per-stage source and load enable; a free stage behind a stalled
    // one gets no load and therefore falls through to a bubble.
    always_comb begin
        ld       = '0;
        src_v    = '0;
        ld[0]    = 1'b1;
        src_v[0] = q.in_valid;
        src_d[0] = q.in_data;
        for (int i = 1; i < DEPTH; i++) begin
            ld[i]    = ~stall[i-1];
            src_v[i] = sv[i-1];
            src_d[i] = sd[i-1];
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        ctrl_queue_stage #(
            .WIDTH  (WIDTH),
            .BUBBLE (BUBBLE)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .load    (ld[i]),
            .hold    (h[i]),
            .kill    (flush[i]),
            .d_valid (src_v[i]),
            .d_data  (src_d[i]),
            .q_valid (sv[i]),
            .q_data  (sd[i])
        );
        assign q.tap_data[i*WIDTH +: WIDTH] = sd[i];
    end

    assign q.tap_valid = sv;
    assign q.out_valid = sv[DEPTH-1];
    assign q.out_data  = sd[DEPTH-1];
    assign q.in_ready  = ~h[0];

`ifdef CTRL_PIPE_QUEUE_OCC_EN
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] nv;
    logic [DEPTH-1:0] r4;
    logic [OCC_W-1:0] occ_nxt;

    // Next-edge valid of each stage and where a bubble is inserted behind a stall.
    always_comb begin
        nv      = '0;
        r4      = '0;
        occ_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (flush[i])    nv[i] = 1'b0;
            else if (h[i])   nv[i] = sv[i];
            else if (ld[i])  nv[i] = src_v[i];
            else             nv[i] = 1'b0;
            if (i > 0) r4[i] = ~flush[i] & ~h[i] & stall[i-1];
            occ_nxt = occ_nxt + OCC_W'(nv[i]);
        end
    end

    // Occupancy and saturating bubble counter, same edge as the stages.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ        <= '0;
            bubble_cnt <= '0;
        end else begin
            occ <= occ_nxt;
            if ((|r4) && (bubble_cnt != 16'hFFFF)) begin
                bubble_cnt <= bubble_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_pipe_queue.sv
// Bench for ctrl_pipe_queue: DEPTH=2 vector table plus hand sequences for
// asynchronous mid-run reset and a DEPTH=4 stall/bubble scenario.
module tb_ctrl_pipe_queue;

    logic clk;
    logic rst_n;
    logic [1:0] st2, fl2;
    logic [3:0] st4, fl4;

    int checks = 0;
    int fails  = 0;

    ctrl_pipe_queue_if #(.WIDTH(5), .DEPTH(2)) q2 ();
    ctrl_pipe_queue_if #(.WIDTH(5), .DEPTH(4)) q4 ();

`ifdef CTRL_PIPE_QUEUE_OCC_EN
    logic [1:0]  occ2;
    logic [15:0] bcnt2;
    logic [2:0]  occ4;
    logic [15:0] bcnt4;
`endif

    ctrl_pipe_queue #(.WIDTH(5), .DEPTH(2)) u2 (
        .clk        (clk),
        .reset      (rst_n),
        .stall      (st2),
        .flush      (fl2),
`ifdef CTRL_PIPE_QUEUE_OCC_EN
        .occ        (occ2),
        .bubble_cnt (bcnt2),
`endif
        .q          (q2)
    );

    ctrl_pipe_queue #(.WIDTH(5), .DEPTH(4)) u4 (
        .clk        (clk),
        .reset      (rst_n),
        .stall      (st4),
        .flush      (fl4),
`ifdef CTRL_PIPE_QUEUE_OCC_EN
        .occ        (occ4),
        .bubble_cnt (bcnt4),
`endif
        .q          (q4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] din;
        logic       vin;
        logic [1:0] st;
        logic [1:0] fl;
        logic       rdy;
        logic [4:0] odat;
        logic       oval;
        logic [9:0] tap;
        logic [1:0] tv;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mk(logic [4:0] din, logic vin, logic [1:0] st, logic [1:0] fl,
                                logic rdy, logic [4:0] odat, logic oval, logic [4:0] tap1,
                                logic [4:0] tap0, logic [1:0] tv);
        vec_t v;
        v.din = din; v.vin = vin; v.st = st; v.fl = fl; v.rdy = rdy;
        v.odat = odat; v.oval = oval; v.tap = {tap1, tap0}; v.tv = tv;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    initial begin
        //              din  vin st     fl     rdy odat  ov  tap1   tap0   tv
        vecs[0]  = mk(5'h02, 1, 2'b00, 2'b00, 1, 5'h00, 0, 5'h00, 5'h02, 2'b01);
        vecs[1]  = mk(5'h0C, 1, 2'b00, 2'b00, 1, 5'h02, 1, 5'h02, 5'h0C, 2'b11);
        vecs[2]  = mk(5'h0E, 1, 2'b10, 2'b00, 0, 5'h02, 1, 5'h02, 5'h0C, 2'b11);
        vecs[3]  = mk(5'h0E, 1, 2'b00, 2'b00, 1, 5'h0C, 1, 5'h0C, 5'h0E, 2'b11);
        vecs[4]  = mk(5'h11, 1, 2'b01, 2'b00, 0, 5'h00, 0, 5'h00, 5'h0E, 2'b01);
        vecs[5]  = mk(5'h11, 1, 2'b00, 2'b00, 1, 5'h0E, 1, 5'h0E, 5'h11, 2'b11);
        vecs[6]  = mk(5'h1F, 1, 2'b00, 2'b00, 1, 5'h11, 1, 5'h11, 5'h1F, 2'b11);
        vecs[7]  = mk(5'h03, 1, 2'b00, 2'b00, 1, 5'h1F, 1, 5'h1F, 5'h03, 2'b11);
        vecs[8]  = mk(5'h03, 1, 2'b10, 2'b10, 0, 5'h00, 0, 5'h00, 5'h03, 2'b01);
        vecs[9]  = mk(5'h03, 1, 2'b00, 2'b01, 1, 5'h03, 1, 5'h03, 5'h00, 2'b10);
        vecs[10] = mk(5'h15, 0, 2'b00, 2'b00, 1, 5'h00, 0, 5'h00, 5'h15, 2'b00);
        vecs[11] = mk(5'h0A, 1, 2'b00, 2'b00, 1, 5'h15, 0, 5'h15, 5'h0A, 2'b01);
        vecs[12] = mk(5'h0A, 1, 2'b11, 2'b11, 0, 5'h00, 0, 5'h00, 5'h00, 2'b00);
        vecs[13] = mk(5'h07, 1, 2'b00, 2'b00, 1, 5'h00, 0, 5'h00, 5'h07, 2'b01);
        vecs[14] = mk(5'h09, 1, 2'b00, 2'b00, 1, 5'h07, 1, 5'h07, 5'h09, 2'b11);

        rst_n = 1'b0;
        st2 = '0; fl2 = '0; st4 = '0; fl4 = '0;
        q2.in_data = '0; q2.in_valid = 1'b0;
        q4.in_data = '0; q4.in_valid = 1'b0;

        #3;
        chk("rst out_valid", 32'(q2.out_valid), 32'h0);
        chk("rst out_data",  32'(q2.out_data),  32'h0);
        chk("rst tap_valid", 32'(q2.tap_valid), 32'h0);
        chk("rst in_ready",  32'(q2.in_ready),  32'h1);
        chk("rst d4 tap_valid", 32'(q4.tap_valid), 32'h0);
        #9 rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            q2.in_data  = vecs[i].din;
            q2.in_valid = vecs[i].vin;
            st2 = vecs[i].st;
            fl2 = vecs[i].fl;
            #1;
            chk($sformatf("v%0d in_ready", i), 32'(q2.in_ready), 32'(vecs[i].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out_data", i),  32'(q2.out_data),  32'(vecs[i].odat));
            chk($sformatf("v%0d out_valid", i), 32'(q2.out_valid), 32'(vecs[i].oval));
            chk($sformatf("v%0d tap_data", i),  32'(q2.tap_data),  32'(vecs[i].tap));
            chk($sformatf("v%0d tap_valid", i), 32'(q2.tap_valid), 32'(vecs[i].tv));
        end

        // Asynchronous reset between edges with both stages full.
        st2 = '0; fl2 = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst out_valid", 32'(q2.out_valid), 32'h0);
        chk("midrst out_data",  32'(q2.out_data),  32'h0);
        chk("midrst tap_data",  32'(q2.tap_data),  32'h0);
        chk("midrst tap_valid", 32'(q2.tap_valid), 32'h0);
        chk("midrst in_ready",  32'(q2.in_ready),  32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        q2.in_data = 5'h1B; q2.in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("post-rst tap_data",  32'(q2.tap_data),  32'({5'h00, 5'h1B}));
        chk("post-rst tap_valid", 32'(q2.tap_valid), 32'h1);
        chk("post-rst out_valid", 32'(q2.out_valid), 32'h0);
        q2.in_valid = 1'b0;

        // DEPTH=4: fill, then stall stage 2 for three edges.
        for (int k = 0; k < 4; k++) begin
            q4.in_data  = 5'(k + 1);
            q4.in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("d4 fill out_data",  32'(q4.out_data),  32'h01);
        chk("d4 fill out_valid", 32'(q4.out_valid), 32'h1);
        chk("d4 fill tap_data",  32'(q4.tap_data),  32'({5'h01, 5'h02, 5'h03, 5'h04}));
        chk("d4 fill tap_valid", 32'(q4.tap_valid), 32'hF);
`ifdef CTRL_PIPE_QUEUE_OCC_EN
        chk("d4 fill occ",        32'(occ4),  32'h4);
        chk("d4 fill bubble_cnt", 32'(bcnt4), 32'h0);
`endif
        q4.in_data = 5'h05;
        st4 = 4'b0100;
        #1;
        chk("d4 stall in_ready", 32'(q4.in_ready), 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
        end
        chk("d4 stall out_valid", 32'(q4.out_valid), 32'h0);
        chk("d4 stall tap_valid", 32'(q4.tap_valid), 32'h7);
        chk("d4 stall tap_data",  32'(q4.tap_data),  32'({5'h00, 5'h02, 5'h03, 5'h04}));
`ifdef CTRL_PIPE_QUEUE_OCC_EN
        chk("d4 stall occ",        32'(occ4),  32'h3);
        chk("d4 stall bubble_cnt", 32'(bcnt4), 32'h3);
`endif
        st4 = 4'b0000;
        @(posedge clk);
        #1;
        chk("d4 resume out_data",  32'(q4.out_data),  32'h02);
        chk("d4 resume out_valid", 32'(q4.out_valid), 32'h1);
        chk("d4 resume tap_data",  32'(q4.tap_data),  32'({5'h02, 5'h03, 5'h04, 5'h05}));
`ifdef CTRL_PIPE_QUEUE_OCC_EN
        chk("d4 resume occ",        32'(occ4),  32'h4);
        chk("d4 resume bubble_cnt", 32'(bcnt4), 32'h3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
